// File: rtl/adder_arb_pkg.sv
// Shared types and helpers for the round-robin adder arbiter.
package adder_arb_pkg;

    typedef enum logic {StArb, StLock} state_e;

    localparam int unsigned DefWidth = 32;
    localparam int unsigned DefNreq  = 4;
    localparam int unsigned MaxReq   = 8;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } pick_t;

    // First set bit of valid at or above ptr, wrapping modulo nreq.
    function automatic pick_t rr_pick(input logic [MaxReq-1:0] valid,
                                      input logic [2:0]        ptr,
                                      input logic [3:0]        nreq);
        pick_t      r;
        logic [3:0] j;
        r = '0;
        for (int i = 0; i < MaxReq; i++) begin
            j = {1'b0, ptr} + 4'(i);
            if (j >= nreq) j = j - nreq;
            if (!r.found && (4'(i) < nreq) && valid[j[2:0]]) begin
                r.found = 1'b1;
                r.idx   = j[2:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/adder_core.sv
// Combinational WIDTH-bit adder with carry-in, carry-out and zero flag.
module adder_core
    import adder_arb_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth
) (
    input  logic [WIDTH-1:0] i_x,
    input  logic [WIDTH-1:0] i_y,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic             o_zero
);

    assign {o_cout, o_sum} = {1'b0, i_x} + {1'b0, i_y} + {{WIDTH{1'b0}}, i_cin};
    assign o_zero          = (o_sum == '0);

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one adder among NREQ requesters, with chained
// multi-word operations and a registered valid/ready result stage.
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth,
    parameter int unsigned NREQ  = DefNreq,
    parameter int unsigned IDW   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_x,
    input  logic [NREQ*WIDTH-1:0] req_y,
    input  logic [NREQ-1:0]       req_cin,
    input  logic [NREQ-1:0]       req_last,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_sum,
    output logic                  rsp_cout,
    output logic                  rsp_zero,
    output logic                  rsp_zero_all,
    output logic                  rsp_last
);

    state_e           r_state, w_state_d;
    logic [IDW-1:0]   r_owner, r_rr_ptr, w_gnt, w_ptr_next;
    logic             r_carry, r_zacc;
    logic             r_rsp_valid, r_rsp_cout, r_rsp_zero, r_rsp_zero_all, r_rsp_last;
    logic [IDW-1:0]   r_rsp_id;
    logic [WIDTH-1:0] r_rsp_sum;
    logic             w_stall, w_found, w_accept, w_cin, w_cout, w_zero, w_zero_all;
    logic [WIDTH-1:0] w_x, w_y, w_sum;
    logic [MaxReq-1:0] w_valid_ext;
    logic [2:0]       w_ptr_ext;
    pick_t            w_pick;

    assign w_stall = r_rsp_valid & ~rsp_ready;

    // In LOCK only the owner can be granted; other valids are ignored.
    always_comb begin
        w_valid_ext            = '0;
        w_valid_ext[NREQ-1:0]  = req_valid;
        w_ptr_ext              = '0;
        w_ptr_ext[IDW-1:0]     = r_rr_ptr;
        w_pick                 = rr_pick(w_valid_ext, w_ptr_ext, 4'(NREQ));
        if (r_state == StLock) begin
            w_gnt   = r_owner;
            w_found = req_valid[r_owner];
        end else begin
            w_gnt   = w_pick.idx[IDW-1:0];
            w_found = w_pick.found;
        end
        req_ready = '0;
        if (!rst && !w_stall && w_found) req_ready[w_gnt] = 1'b1;
    end

    assign w_accept   = |req_ready;
    assign w_x        = req_x[w_gnt*WIDTH +: WIDTH];
    assign w_y        = req_y[w_gnt*WIDTH +: WIDTH];
    assign w_cin      = (r_state == StLock) ? r_carry : req_cin[w_gnt];
    assign w_zero_all = w_zero & ((r_state == StArb) | r_zacc);
    assign w_ptr_next = (w_gnt == IDW'(NREQ - 1)) ? '0 : w_gnt + 1'b1;

    adder_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .i_x   (w_x),
        .i_y   (w_y),
        .i_cin (w_cin),
        .o_sum (w_sum),
        .o_cout(w_cout),
        .o_zero(w_zero)
    );

    always_comb begin
        w_state_d = r_state;
        if (w_accept) w_state_d = req_last[w_gnt] ? StArb : StLock;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= StArb;
        else     r_state <= w_state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner        <= '0;
            r_rr_ptr       <= '0;
            r_carry        <= 1'b0;
            r_zacc         <= 1'b1;
            r_rsp_valid    <= 1'b0;
            r_rsp_id       <= '0;
            r_rsp_sum      <= '0;
            r_rsp_cout     <= 1'b0;
            r_rsp_zero     <= 1'b0;
            r_rsp_zero_all <= 1'b0;
            r_rsp_last     <= 1'b0;
        end else if (w_accept) begin
            r_rsp_valid    <= 1'b1;
            r_rsp_id       <= w_gnt;
            r_rsp_sum      <= w_sum;
            r_rsp_cout     <= w_cout;
            r_rsp_zero     <= w_zero;
            r_rsp_zero_all <= w_zero_all;
            r_rsp_last     <= req_last[w_gnt];
            // Pointer moves only when a whole operation completes.
            if (req_last[w_gnt]) begin
                r_rr_ptr <= w_ptr_next;
                r_carry  <= 1'b0;
                r_zacc   <= 1'b1;
            end else begin
                r_owner  <= w_gnt;
                r_carry  <= w_cout;
                r_zacc   <= w_zero_all;
            end
        end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign rsp_valid    = r_rsp_valid;
    assign rsp_id       = r_rsp_id;
    assign rsp_sum      = r_rsp_sum;
    assign rsp_cout     = r_rsp_cout;
    assign rsp_zero     = r_rsp_zero;
    assign rsp_zero_all = r_rsp_zero_all;
    assign rsp_last     = r_rsp_last;

endmodule

// File: tb/tb_adder_arbiter.sv
// Randomised and directed bench for adder_arbiter with a queue scoreboard.
module tb_adder_arbiter;

    localparam int WIDTH = 32;
    localparam int NREQ  = 4;
    localparam int IDW   = 2;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NREQ-1:0]       req_valid, req_ready, req_cin, req_last;
    logic [NREQ*WIDTH-1:0] req_x, req_y;
    logic                  rsp_valid, rsp_ready, rsp_cout, rsp_zero, rsp_zero_all, rsp_last;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_sum;

    logic [NREQ-1:0]  v, cin, lst;
    logic [WIDTH-1:0] xs[NREQ];
    logic [WIDTH-1:0] ys[NREQ];

    typedef struct packed {
        logic [IDW-1:0]   id;
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             zero;
        logic             zall;
        logic             last;
    } rsp_t;

    rsp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Reference state, expressed directly in terms of the arbitration rules.
    int m_ptr = 0, m_owner = 0;
    bit m_lock = 0, m_carry = 0, m_zacc = 1, m_rv = 0;

    always #5 clk = ~clk;

    assign req_valid = v;
    assign req_cin   = cin;
    assign req_last  = lst;
    always_comb begin
        req_x = '0;
        req_y = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_x[i*WIDTH +: WIDTH] = xs[i];
            req_y[i*WIDTH +: WIDTH] = ys[i];
        end
    end

    adder_arbiter #(
        .WIDTH(WIDTH),
        .NREQ (NREQ),
        .IDW  (IDW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_x       (req_x),
        .req_y       (req_y),
        .req_cin     (req_cin),
        .req_last    (req_last),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_sum     (rsp_sum),
        .rsp_cout    (rsp_cout),
        .rsp_zero    (rsp_zero),
        .rsp_zero_all(rsp_zero_all),
        .rsp_last    (rsp_last)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, " req_ready"}, 64'(req_ready), 0);
        chk({tag, " rsp_valid"}, 64'(rsp_valid), 0);
        chk({tag, " rsp_id"}, 64'(rsp_id), 0);
        chk({tag, " rsp_sum"}, 64'(rsp_sum), 0);
        chk({tag, " rsp_flags"}, 64'({rsp_cout, rsp_zero, rsp_zero_all, rsp_last}), 0);
    endtask

    // Evaluate the reference at the falling edge, then return just after the
    // next rising edge so the caller can drive the following cycle's inputs.
    task automatic tick();
        logic [NREQ-1:0] er;
        int              g;
        bit              stall, c;
        longint          full;
        rsp_t            e;
        @(negedge clk);
        er = '0;
        g  = -1;
        if (rst) begin
            m_ptr = 0; m_lock = 0; m_carry = 0; m_zacc = 1; m_rv = 0;
            sb.delete();
        end else begin
            stall = m_rv && !rsp_ready;
            if (!stall) begin
                if (m_lock) begin
                    if (v[m_owner]) g = m_owner;
                end else begin
                    for (int k = 0; k < NREQ; k++) begin
                        int idx;
                        idx = (m_ptr + k) % NREQ;
                        if (g < 0 && v[idx]) g = idx;
                    end
                end
            end
            if (g >= 0) er[g] = 1'b1;
        end
        chk("req_ready", 64'(req_ready), 64'(er));
        chk("rsp_valid", 64'(rsp_valid), 64'(m_rv));
        if (!rst) begin
            if (g >= 0) begin
                c      = m_lock ? m_carry : cin[g];
                full   = longint'(xs[g]) + longint'(ys[g]) + longint'(c);
                e.id   = g[IDW-1:0];
                e.sum  = full[WIDTH-1:0];
                e.cout = full[WIDTH];
                e.zero = (e.sum == 0);
                e.zall = e.zero && (m_lock ? m_zacc : 1'b1);
                e.last = lst[g];
                sb.push_back(e);
                m_rv = 1;
                if (lst[g]) begin
                    m_lock = 0; m_ptr = (g + 1) % NREQ; m_carry = 0; m_zacc = 1;
                end else begin
                    m_lock = 1; m_owner = g; m_carry = e.cout; m_zacc = e.zall;
                end
            end else if (rsp_ready) begin
                m_rv = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: every result the consumer takes must match the queue head.
    initial begin
        rsp_t e;
        forever begin
            @(posedge clk);
            #3;
            if (!rst && rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL sb_empty: got response id=%0d sum=%0h, expected none",
                             rsp_id, rsp_sum);
                end else begin
                    e = sb.pop_front();
                    chk("sb rsp_id", 64'(rsp_id), 64'(e.id));
                    chk("sb rsp_sum", 64'(rsp_sum), 64'(e.sum));
                    chk("sb rsp_cout", 64'(rsp_cout), 64'(e.cout));
                    chk("sb rsp_zero", 64'(rsp_zero), 64'(e.zero));
                    chk("sb rsp_zero_all", 64'(rsp_zero_all), 64'(e.zall));
                    chk("sb rsp_last", 64'(rsp_last), 64'(e.last));
                end
            end
        end
    end

    initial begin
        logic [63:0] snap;
        v = '0; cin = '0; lst = '0; rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            xs[i] = '0;
            ys[i] = '0;
        end

        // Reset state
        tick();
        tick();
        chk_zero_outputs("reset");
        rst = 1'b0;

        // Single op: 5 + 7 + 1
        v = 4'b0001; lst = 4'b0001; cin = 4'b0001; xs[0] = 5; ys[0] = 7;
        tick();
        chk("single sum", 64'(rsp_sum), 13);
        chk("single flags", 64'({rsp_id, rsp_cout, rsp_zero, rsp_last}), 64'({2'd0, 3'b001}));

        // Overflow to zero on req1
        v = 4'b0010; lst = 4'b0010; cin = '0; xs[1] = 32'hFFFF_FFFF; ys[1] = 1;
        tick();
        chk("ovf sum", 64'(rsp_sum), 0);
        chk("ovf flags", 64'({rsp_cout, rsp_zero, rsp_zero_all}), 64'(3'b111));

        // Chained add on req1; req0 must be ignored while locked
        v = 4'b0010; lst = 4'b0000; cin = 4'b0010; xs[1] = 32'hFFFF_FFFF; ys[1] = 0;
        tick();
        chk("chain0 sum", 64'(rsp_sum), 0);
        chk("chain0 flags", 64'({rsp_id, rsp_cout, rsp_zero_all}), 64'({2'd1, 2'b11}));
        v = 4'b0011; lst = 4'b0011; cin = 4'b0000; xs[1] = 0; ys[1] = 0;
        tick();
        chk("chain1 sum", 64'(rsp_sum), 1);
        chk("chain1 flags", 64'({rsp_id, rsp_cout, rsp_zero_all, rsp_last}), 64'({2'd1, 3'b001}));
        v = 4'b0111; lst = 4'b1111;
        tick();
        chk("after chain id", 64'(rsp_id), 2);

        // Round robin with all requesters valid: 3 then 0,1,2,3,0
        v = 4'b1111;
        tick();
        for (int k = 0; k < 5; k++) begin
            xs[k % NREQ] = 32'(k * 10);
            tick();
            chk("rr id", 64'(rsp_id), 64'(k % NREQ));
            chk("rr valid", 64'(rsp_valid), 1);
        end

        // Backpressure: result pending, consumer stalled
        v = '0; rsp_ready = 1'b0;
        tick();
        snap = 64'({rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_zero, rsp_zero_all, rsp_last});
        v = 4'b1000; xs[3] = 100; ys[3] = 23; cin = '0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("stall hold", 64'({rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_zero, rsp_zero_all,
                                  rsp_last}), snap);
        end
        rsp_ready = 1'b1;
        tick();
        chk("unstall id", 64'(rsp_id), 3);
        chk("unstall sum", 64'(rsp_sum), 123);

        // Reset mid-chain drops lock and carry
        v = 4'b0001; lst = 4'b0000; cin = '0; xs[0] = 32'hFFFF_FFFF; ys[0] = 1;
        tick();
        chk("prereset valid", 64'(rsp_valid), 1);
        rst = 1'b1;
        #1;
        chk_zero_outputs("async reset");
        tick();
        rst = 1'b0;
        v = 4'b0100; lst = 4'b0100; cin = '0; xs[2] = 1; ys[2] = 1;
        tick();
        chk("post reset id", 64'(rsp_id), 2);
        chk("post reset sum", 64'(rsp_sum), 2);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            v         = NREQ'($urandom);
            cin       = NREQ'($urandom);
            lst       = NREQ'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NREQ; i++) begin
                xs[i] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
                ys[i] = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom_range(0, 3);
            end
            tick();
        end

        // Drain
        v = '0; rsp_ready = 1'b1;
        repeat (3) tick();
        chk("sb drained", 64'(sb.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
